topk_result_drain: RTL and testbench



---
 rtl/topk_result_drain.sv | 137 +++++++++++++
 tb/tb_topk_result_drain.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/topk_result_drain.sv
// Top-5 sorter result drain: captures final packed results into a
// two-deep buffer and streams kept entries one beat per cycle.
module topk_result_drain #(
  parameter int                    Data_Width  = 8,
  parameter int                    Index_Width = 16,
  parameter int                    N           = 5,
  parameter logic [Data_Width-1:0] Data_init   = 'h80,
  parameter bit                    SKIP_EMPTY  = 1'b1
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   sorter_clr,
  input  logic [255:0]           sorter_result,
  input  logic                   sorter_valid,
  input  logic                   last_sort_o,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [Index_Width-1:0] out_index,
  output logic [Data_Width-1:0]  out_data,
  output logic [2:0]             out_rank,
  output logic                   out_last,
  output logic                   busy,
  output logic                   overflow
);

  localparam int EW = Data_Width + Index_Width;
  localparam int RW = N * EW;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state;
  logic [RW-1:0]   a_q;
  logic [RW-1:0]   p_q;
  logic [N-1:0]    a_keep;
  logic [N-1:0]    p_keep;
  logic            p_full;
  logic            ovf_q;

  logic [RW-1:0]   res_in;
  logic [N-1:0]    keep_in;
  logic [N-1:0]    sel_oh;
  logic [N-1:0]    rest;
  logic [2:0]      sel;
  logic            found;
  logic [EW-1:0]   entry;
  logic            is_last;
  logic            xfer;
  logic            fin;
  logic            cap;
  logic            unused_hi;

  assign res_in    = sorter_result[RW-1:0];
  assign unused_hi = ^sorter_result[255:RW];

  always_comb begin
    keep_in = '0;
    for (int k = 0; k < N; k++) begin
      keep_in[k] = !(SKIP_EMPTY &&
        (res_in[k*EW +: Data_Width] == Data_init));
    end
    // a frame always carries at least one beat
    if (keep_in == '0) keep_in[0] = 1'b1;
  end

  always_comb begin
    sel    = '0;
    sel_oh = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (a_keep[k] && !found) begin
        sel       = 3'(k);
        sel_oh[k] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign rest    = a_keep & ~sel_oh;
  assign is_last = (rest == '0);
  assign entry   = a_q[int'(sel)*EW +: EW];

  assign out_valid = (state == SEND);
  assign out_data  = out_valid ? entry[Data_Width-1:0] : '0;
  assign out_index = out_valid ? entry[EW-1:Data_Width] : '0;
  assign out_rank  = out_valid ? sel : '0;
  assign out_last  = out_valid && is_last;
  assign busy      = out_valid || p_full;
  assign overflow  = ovf_q;

  assign xfer = out_valid && out_ready;
  assign fin  = xfer && is_last;
  assign cap  = sorter_valid && last_sort_o;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      p_q    <= '0;
      a_keep <= '0;
      p_keep <= '0;
      p_full <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (sorter_clr) begin
      state  <= IDLE;
      a_keep <= '0;
      p_keep <= '0;
      p_full <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (xfer) a_keep <= rest;
      if (fin) begin
        if (p_full) begin
          a_q    <= p_q;
          a_keep <= p_keep;
          p_full <= 1'b0;
        end else begin
          state <= IDLE;
        end
      end
      // later assignments win when a capture meets a final beat
      if (cap) begin
        if ((state == IDLE || fin) && !p_full) begin
          a_q    <= res_in;
          a_keep <= keep_in;
          state  <= SEND;
        end else if (!p_full || fin) begin
          p_q    <= res_in;
          p_keep <= keep_in;
          p_full <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_topk_result_drain.sv
// Bench for topk_result_drain: frame-queue reference model plus
// directed scenarios with literal expectations.
module tb_topk_result_drain;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         sorter_clr = 1'b0;
  logic [255:0] sorter_result = '0;
  logic         sorter_valid = 1'b0;
  logic         last_sort_o = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [15:0]  out_index;
  logic [7:0]   out_data;
  logic [2:0]   out_rank;
  logic         out_last;
  logic         busy;
  logic         overflow;

  always #5 sys_clk = ~sys_clk;

  topk_result_drain dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .sorter_clr(sorter_clr), .sorter_result(sorter_result),
    .sorter_valid(sorter_valid), .last_sort_o(last_sort_o),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_data(out_data),
    .out_rank(out_rank), .out_last(out_last),
    .busy(busy), .overflow(overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  typedef struct {
    logic [2:0]  rank;
    logic [15:0] idx;
    logic [7:0]  data;
    logic        last;
    int          cyc;
  } beat_t;
  typedef beat_t bq_t[$];

  // a frame is the ordered list of non-empty slots; never empty
  function automatic bq_t beats_of(logic [255:0] r);
    bq_t q;
    beat_t b;
    for (int k = 0; k < 5; k++) begin
      if (r[k*24 +: 8] != 8'h80) begin
        b.rank = 3'(k);
        b.idx  = r[k*24+8 +: 16];
        b.data = r[k*24 +: 8];
        b.last = 1'b0;
        b.cyc  = 0;
        q.push_back(b);
      end
    end
    if (q.size() == 0) begin
      b.rank = 3'd0;
      b.idx  = r[23:8];
      b.data = r[7:0];
      b.last = 1'b0;
      b.cyc  = 0;
      q.push_back(b);
    end
    q[q.size()-1].last = 1'b1;
    return q;
  endfunction

  function automatic logic [255:0] mk(
    input logic [7:0] d0, d1, d2, d3, d4,
    input logic [15:0] i0, i1, i2, i3, i4);
    logic [255:0] r;
    r = '1;
    r[119:0] = {i4, d4, i3, d3, i2, d2, i1, d1, i0, d0};
    return r;
  endfunction

  bq_t m_act;
  bq_t m_pend;
  bit  m_pfull;
  bit  m_ovf;

  always @(posedge sys_clk) cyc++;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_act.delete();
      m_pend.delete();
      m_pfull = 0;
      m_ovf = 0;
    end else if (sorter_clr) begin
      m_act.delete();
      m_pend.delete();
      m_pfull = 0;
      m_ovf = 0;
    end else begin
      if (m_act.size() > 0 && out_ready) begin
        void'(m_act.pop_front());
        if (m_act.size() == 0 && m_pfull) begin
          m_act = m_pend;
          m_pfull = 0;
        end
      end
      if (sorter_valid && last_sort_o) begin
        if (m_act.size() == 0 && !m_pfull)
          m_act = beats_of(sorter_result);
        else if (!m_pfull) begin
          m_pend = beats_of(sorter_result);
          m_pfull = 1;
        end else
          m_ovf = 1;
      end
    end
  end

  bq_t  log_q;
  bit   stall = 0;
  logic [15:0] s_idx;
  logic [7:0]  s_data;
  logic [2:0]  s_rank;
  logic        s_last;

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      chk("valid", out_valid, m_act.size() > 0);
      chk("busy", busy, (m_act.size() > 0) || m_pfull);
      chk("overflow", overflow, m_ovf);
      if (m_act.size() > 0) begin
        chk("rank", out_rank, m_act[0].rank);
        chk("index", out_index, m_act[0].idx);
        chk("data", out_data, m_act[0].data);
        chk("last", out_last, m_act[0].last);
      end
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_index", out_index, s_idx);
        chk("stall_data", out_data, s_data);
        chk("stall_rank", out_rank, s_rank);
        chk("stall_last", out_last, s_last);
      end
      stall  = out_valid && !out_ready && !sorter_clr;
      s_idx  = out_index;
      s_data = out_data;
      s_rank = out_rank;
      s_last = out_last;
      if (out_valid && out_ready) begin
        beat_t b;
        b.rank = out_rank;
        b.idx  = out_index;
        b.data = out_data;
        b.last = out_last;
        b.cyc  = cyc;
        log_q.push_back(b);
      end
    end else begin
      stall = 0;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cap(logic [255:0] r, logic ls = 1'b1);
    sorter_result = r;
    sorter_valid  = 1'b1;
    last_sort_o   = ls;
    tick();
    sorter_valid  = 1'b0;
    last_sort_o   = 1'b0;
  endtask

  task automatic wait_idle(string nm);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (!busy) done = 1;
      else tick();
    end
    if (!done) chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic chk_log(string nm, int i, int rk, int ix,
                         int d, int l);
    if (i < log_q.size()) begin
      chk({nm, "_rank"}, log_q[i].rank, rk);
      chk({nm, "_idx"}, log_q[i].idx, ix);
      chk({nm, "_data"}, log_q[i].data, d);
      chk({nm, "_last"}, log_q[i].last, l);
    end else begin
      chk({nm, "_missing"}, log_q.size(), i + 1);
    end
  endtask

  logic [255:0] r1, r2, r3, fa, fb, fc, g3;
  bit pat [4] = '{1, 0, 0, 1};

  initial begin
    r1 = mk(8'h40, 8'h30, 8'h20, 8'h10, 8'h05,
            16'd7, 16'd3, 16'd9, 16'd1, 16'd2);
    r2 = mk(8'h44, 8'h33, 8'h22, 8'h80, 8'h80,
            16'd11, 16'd12, 16'd13, 16'd14, 16'd15);
    r3 = mk(8'h80, 8'h80, 8'h80, 8'h80, 8'h80,
            16'd21, 16'd22, 16'd23, 16'd24, 16'd25);
    fa = mk(8'h90, 8'h70, 8'h50, 8'h30, 8'h10,
            16'd100, 16'd101, 16'd102, 16'd103, 16'd104);
    fb = mk(8'h91, 8'h71, 8'h51, 8'h31, 8'h11,
            16'd200, 16'd201, 16'd202, 16'd203, 16'd204);
    fc = mk(8'h92, 8'h72, 8'h52, 8'h32, 8'h12,
            16'd300, 16'd301, 16'd302, 16'd303, 16'd304);
    g3 = mk(8'h93, 8'h73, 8'h53, 8'h33, 8'h13,
            16'd400, 16'd401, 16'd402, 16'd403, 16'd404);

    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_index", out_index, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rank", out_rank, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    sys_rst_n = 1'b1;
    tick();

    // single full frame, continuous ready
    out_ready = 1'b1;
    log_q.delete();
    cap(r1);
    chk("t1_lat_valid", out_valid, 1);
    chk("t1_lat_rank", out_rank, 0);
    wait_idle("t1");
    chk("t1_count", log_q.size(), 5);
    chk_log("t1_b0", 0, 0, 7, 'h40, 0);
    chk_log("t1_b1", 1, 1, 3, 'h30, 0);
    chk_log("t1_b2", 2, 2, 9, 'h20, 0);
    chk_log("t1_b3", 3, 3, 1, 'h10, 0);
    chk_log("t1_b4", 4, 4, 2, 'h05, 1);
    if (log_q.size() == 5)
      chk("t1_nobubble", log_q[4].cyc - log_q[0].cyc, 4);

    // empty-slot suppression
    log_q.delete();
    cap(r2);
    wait_idle("t2a");
    chk("t2a_count", log_q.size(), 3);
    chk_log("t2a_b1", 1, 1, 12, 'h33, 0);
    chk_log("t2a_b2", 2, 2, 13, 'h22, 1);
    log_q.delete();
    cap(r3);
    wait_idle("t2b");
    chk("t2b_count", log_q.size(), 1);
    chk_log("t2b_b0", 0, 0, 21, 'h80, 1);

    // backpressure pattern 1,0,0,1
    out_ready = 1'b0;
    log_q.delete();
    cap(r1);
    for (int i = 0; i < 60 && busy; i++) begin
      out_ready = pat[i % 4];
      tick();
    end
    chk("t3_done", busy, 0);
    chk("t3_count", log_q.size(), 5);
    chk_log("t3_b0", 0, 0, 7, 'h40, 0);
    chk_log("t3_b2", 2, 2, 9, 'h20, 0);
    chk_log("t3_b4", 4, 4, 2, 'h05, 1);

    // three captures while stalled: third dropped
    out_ready = 1'b0;
    log_q.delete();
    cap(fa);
    cap(fb);
    chk("t4_busy2", busy, 1);
    chk("t4_ovf2", overflow, 0);
    cap(fc);
    chk("t4_ovf3", overflow, 1);
    out_ready = 1'b1;
    wait_idle("t4");
    chk("t4_count", log_q.size(), 10);
    chk_log("t4_b0", 0, 0, 100, 'h90, 0);
    chk_log("t4_b4", 4, 4, 104, 'h10, 1);
    chk_log("t4_b5", 5, 0, 200, 'h91, 0);
    chk_log("t4_b9", 9, 4, 204, 'h11, 1);
    chk("t4_ovf_sticky", overflow, 1);
    out_ready = 1'b0;
    cap(fa);
    chk("t4_busy_pre_clr", busy, 1);
    sorter_clr    = 1'b1;
    sorter_valid  = 1'b1;
    last_sort_o   = 1'b1;
    sorter_result = fb;
    tick();
    sorter_clr   = 1'b0;
    sorter_valid = 1'b0;
    last_sort_o  = 1'b0;
    chk("t4_clr_busy", busy, 0);
    chk("t4_clr_ovf", overflow, 0);
    chk("t4_clr_valid", out_valid, 0);

    // final beat of A coincides with capture while P full
    log_q.delete();
    cap(fa);
    cap(fb);
    out_ready = 1'b1;
    repeat (4) tick();
    cap(g3);
    wait_idle("t5");
    chk("t5_count", log_q.size(), 15);
    chk_log("t5_b4", 4, 4, 104, 'h10, 1);
    chk_log("t5_b5", 5, 0, 200, 'h91, 0);
    chk_log("t5_b10", 10, 0, 400, 'h93, 0);
    if (log_q.size() == 15)
      chk("t5_nogap", log_q[14].cyc - log_q[0].cyc, 14);
    chk("t5_ovf", overflow, 0);

    // non-final pulses ignored; async reset mid-frame
    cap(r1, 1'b0);
    cap(fa, 1'b0);
    tick();
    chk("t6_ign_valid", out_valid, 0);
    chk("t6_ign_busy", busy, 0);
    out_ready = 1'b0;
    cap(r1);
    tick();
    chk("t6_pre_valid", out_valid, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_index", out_index, 0);
    #10 sys_rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    log_q.delete();
    cap(r1);
    wait_idle("t6");
    chk("t6_count", log_q.size(), 5);
    chk_log("t6_b0", 0, 0, 7, 'h40, 0);
    chk_log("t6_b4", 4, 4, 2, 'h05, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
